cms_trace_gate: RTL and testbench

- Parametrised successor to the single-window trace qualifier in the continuous monitoring system.
- Qualifies the retired-instruction stream (pc/instr/pc_valid) against NUM_RANGES address windows and NUM_TRIGGERS start/end trigger pairs.
- Trace is gated by an armable one-shot/continuous state machine, with optional decimation.
- Emits qualified packets on a valid/ready stream with a 1-entry output register, saturating drop counter and per-packet timestamp delta.
- Sits between the core trace port and the AXI-stream packer.

---
 rtl/cms_trace_gate_pkg.sv | 31 +++
 rtl/cms_trace_gate_if.sv | 31 +++
 rtl/cms_window_match.sv | 39 +++
 rtl/edge_detector.sv | 22 ++
 rtl/cms_trace_gate.sv | 234 +++++++++++++++++++++++
 tb/tb_cms_trace_gate.sv | 294 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cms_trace_gate_pkg.sv
// cms_trace_gate shared types: register map, gate states, CTRL bits.
// Imported by the trace gate top and its interface users.
package cms_trace_gate_pkg;

  typedef enum logic [3:0] {
    ADDR_CTRL       = 4'd0,
    ADDR_DECIM      = 4'd1,
    ADDR_INDEX      = 4'd2,
    ADDR_RANGE_LO   = 4'd3,
    ADDR_RANGE_HI   = 4'd4,
    ADDR_RANGE_EN   = 4'd5,
    ADDR_TRIG_START = 4'd6,
    ADDR_TRIG_END   = 4'd7,
    ADDR_TRIG_EN    = 4'd8
  } cms_gate_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TRACING = 2'd2,
    ST_STOPPED = 2'd3
  } cms_gate_state_t;

  localparam int CTRL_ARM  = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_CLR  = 2;

  localparam int TRIG_EN_START = 0;
  localparam int TRIG_EN_END   = 1;

endpackage

// File: rtl/cms_trace_gate_if.sv
// Qualified-packet stream between the trace gate and the stream packer.
// Master drives the packet, slave returns ready.
interface cms_trace_gate_if #(
  parameter int XLEN        = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int TS_WIDTH    = 32
);

  logic                   valid;
  logic                   ready;
  logic [XLEN-1:0]        pc;
  logic [INSTR_WIDTH-1:0] instr;
  logic [TS_WIDTH-1:0]    delta;

  modport master (
    output valid,
    output pc,
    output instr,
    output delta,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    input  instr,
    input  delta,
    output ready
  );

endinterface

// File: rtl/cms_window_match.sv
// Per-slot compare of the retiring pc against address windows and
// start/end trigger addresses; hits are already masked by slot enables.
module cms_window_match #(
  parameter int XLEN         = 64,
  parameter int NUM_RANGES   = 4,
  parameter int NUM_TRIGGERS = 2
) (
  input  logic [XLEN-1:0]                   pc,
  input  logic [NUM_RANGES-1:0][XLEN-1:0]   lo,
  input  logic [NUM_RANGES-1:0][XLEN-1:0]   hi,
  input  logic [NUM_RANGES-1:0]             range_en,
  input  logic [NUM_TRIGGERS-1:0][XLEN-1:0] start_addr,
  input  logic [NUM_TRIGGERS-1:0][XLEN-1:0] end_addr,
  input  logic [NUM_TRIGGERS-1:0]           start_en,
  input  logic [NUM_TRIGGERS-1:0]           end_en,
  output logic [NUM_RANGES-1:0]             range_hit,
  output logic [NUM_TRIGGERS-1:0]           start_hit,
  output logic [NUM_TRIGGERS-1:0]           end_hit
);

  always_comb begin
    range_hit = '0;
    for (int i = 0; i < NUM_RANGES; i++) begin
      range_hit[i] = range_en[i]
                   & (pc >= lo[i])
                   & (pc <= hi[i]);
    end
  end

  always_comb begin
    start_hit = '0;
    end_hit   = '0;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      start_hit[i] = start_en[i] & (pc == start_addr[i]);
      end_hit[i]   = end_en[i] & (pc == end_addr[i]);
    end
  end

endmodule

// File: rtl/edge_detector.sv
// Rising-edge detector; pulse is combinational in the cycle the input
// first goes high, so a strobe acts without added latency.
module edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/cms_trace_gate.sv
// Trace qualifier: windows + start/end triggers gate the retire stream,
// with decimation, a 1-entry output register and a drop counter.
module cms_trace_gate
  import cms_trace_gate_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int INSTR_WIDTH  = 32,
  parameter int NUM_RANGES   = 4,
  parameter int NUM_TRIGGERS = 2,
  parameter int TS_WIDTH     = 32,
  parameter int DECIM_WIDTH  = 16,
  parameter int DROP_WIDTH   = 32,
  parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [XLEN-1:0]        pc,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   pc_valid,
  input  logic                   en,
  input  logic [3:0]             ctrl_addr,
  input  logic [XLEN-1:0]        ctrl_wdata,
  input  logic                   ctrl_write_enable,
  cms_trace_gate_if.master       out,
  output logic [DROP_WIDTH-1:0]  dropped_count,
  output logic [1:0]             gate_state
);

  cms_gate_state_t state;
  cms_gate_state_t state_n;

  logic                             cont_q;
  logic [DECIM_WIDTH-1:0]           decim_q;
  logic [3:0]                       index_q;
  logic [NUM_RANGES-1:0][XLEN-1:0]  lo_q;
  logic [NUM_RANGES-1:0][XLEN-1:0]  hi_q;
  logic [NUM_RANGES-1:0]            ren_q;
  logic [NUM_TRIGGERS-1:0][XLEN-1:0] tstart_q;
  logic [NUM_TRIGGERS-1:0][XLEN-1:0] tend_q;
  logic [NUM_TRIGGERS-1:0]          sen_q;
  logic [NUM_TRIGGERS-1:0]          een_q;

  logic [DECIM_WIDTH-1:0] dec_cnt;
  logic [DECIM_WIDTH-1:0] cnt_eff;
  logic [DECIM_WIDTH-1:0] cnt_n;
  logic [TS_WIDTH-1:0]    ts_q;
  logic [TS_WIDTH-1:0]    last_q;

  logic                    wr;
  logic                    ctrl_wr;
  logic                    arm;
  logic                    disarm;
  logic [NUM_RANGES-1:0]   range_hit;
  logic [NUM_TRIGGERS-1:0] start_hit;
  logic [NUM_TRIGGERS-1:0] end_hit;
  logic                    start_any;
  logic                    end_any;
  logic                    window_ok;
  logic                    trig_fire;
  logic                    qual;
  logic                    capture;
  logic                    load;
  logic                    drop;

  if (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) begin : g_edge
    edge_detector u_we (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ctrl_write_enable),
      .rise  (wr)
    );
  end else begin : g_level
    assign wr = ctrl_write_enable;
  end

  assign ctrl_wr = wr & (ctrl_addr == ADDR_CTRL);
  assign arm     = ctrl_wdata[CTRL_ARM];
  assign disarm  = ctrl_wr & ~arm;

  cms_window_match #(
    .XLEN         (XLEN),
    .NUM_RANGES   (NUM_RANGES),
    .NUM_TRIGGERS (NUM_TRIGGERS)
  ) u_match (
    .pc         (pc),
    .lo         (lo_q),
    .hi         (hi_q),
    .range_en   (ren_q),
    .start_addr (tstart_q),
    .end_addr   (tend_q),
    .start_en   (sen_q),
    .end_en     (een_q),
    .range_hit  (range_hit),
    .start_hit  (start_hit),
    .end_hit    (end_hit)
  );

  assign start_any = |start_hit;
  assign end_any   = |end_hit;
  assign window_ok = (ren_q == '0) | (|range_hit);

  // With no start trigger enabled, ARMED falls through on its own.
  assign trig_fire = (state == ST_ARMED)
                   & ((sen_q == '0) | (pc_valid & start_any));

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: ;
      ST_ARMED: begin
        if (trig_fire) begin
          state_n = (pc_valid & end_any) ? ST_STOPPED : ST_TRACING;
        end
      end
      ST_TRACING: begin
        if (pc_valid & end_any) state_n = ST_STOPPED;
      end
      ST_STOPPED: begin
        if (cont_q) state_n = ST_ARMED;
      end
      default: state_n = ST_IDLE;
    endcase
    if (ctrl_wr) begin
      if (!arm) begin
        state_n = ST_IDLE;
      end else if (state == ST_IDLE || state == ST_STOPPED) begin
        state_n = ST_ARMED;
      end
    end
  end

  always_comb begin
    qual = en & pc_valid & window_ok & ~disarm
         & ((state == ST_TRACING) | ((state == ST_ARMED) & start_any));
    cnt_eff = trig_fire ? '0 : dec_cnt;
    capture = qual & (cnt_eff == decim_q);
    cnt_n   = cnt_eff;
    if (qual) cnt_n = capture ? '0 : cnt_eff + 1'b1;
    load = capture & (~out.valid | out.ready);
    drop = capture & ~load;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      dec_cnt <= '0;
      ts_q    <= '0;
    end else begin
      state   <= state_n;
      dec_cnt <= cnt_n;
      ts_q    <= ts_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out.valid     <= 1'b0;
      out.pc        <= '0;
      out.instr     <= '0;
      out.delta     <= '0;
      last_q        <= '0;
      dropped_count <= '0;
    end else begin
      if (load) begin
        out.valid <= 1'b1;
        out.pc    <= pc;
        out.instr <= instr;
        out.delta <= ts_q - last_q;
        last_q    <= ts_q;
      end else if (out.ready) begin
        out.valid <= 1'b0;
      end
      if (ctrl_wr && ctrl_wdata[CTRL_CLR]) begin
        dropped_count <= '0;
      end else if (drop && dropped_count != '1) begin
        dropped_count <= dropped_count + 1'b1;
      end
    end
  end

  // Slot writes index through INDEX; out-of-range indices match no slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cont_q   <= 1'b0;
      decim_q  <= '0;
      index_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '1;
      ren_q    <= '0;
      tstart_q <= '0;
      tend_q   <= '0;
      sen_q    <= '0;
      een_q    <= '0;
    end else if (wr) begin
      case (ctrl_addr)
        ADDR_CTRL:  cont_q  <= ctrl_wdata[CTRL_CONT];
        ADDR_DECIM: decim_q <= ctrl_wdata[DECIM_WIDTH-1:0];
        ADDR_INDEX: index_q <= ctrl_wdata[3:0];
        ADDR_RANGE_LO: begin
          for (int i = 0; i < NUM_RANGES; i++)
            if (index_q == 4'(i)) lo_q[i] <= ctrl_wdata;
        end
        ADDR_RANGE_HI: begin
          for (int i = 0; i < NUM_RANGES; i++)
            if (index_q == 4'(i)) hi_q[i] <= ctrl_wdata;
        end
        ADDR_RANGE_EN: begin
          for (int i = 0; i < NUM_RANGES; i++)
            if (index_q == 4'(i)) ren_q[i] <= ctrl_wdata[0];
        end
        ADDR_TRIG_START: begin
          for (int i = 0; i < NUM_TRIGGERS; i++)
            if (index_q == 4'(i)) tstart_q[i] <= ctrl_wdata;
        end
        ADDR_TRIG_END: begin
          for (int i = 0; i < NUM_TRIGGERS; i++)
            if (index_q == 4'(i)) tend_q[i] <= ctrl_wdata;
        end
        ADDR_TRIG_EN: begin
          for (int i = 0; i < NUM_TRIGGERS; i++) begin
            if (index_q == 4'(i)) begin
              sen_q[i] <= ctrl_wdata[TRIG_EN_START];
              een_q[i] <= ctrl_wdata[TRIG_EN_END];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gate_state = state;

endmodule

// File: tb/tb_cms_trace_gate.sv
// Directed bench for cms_trace_gate: windows, triggers, decimation,
// backpressure/drop counter, disarm override and mid-trace reset.
module tb_cms_trace_gate;
  import cms_trace_gate_pkg::*;

  localparam int XLEN = 64;
  localparam int IW   = 32;
  localparam int TSW  = 32;
  localparam int DW   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [IW-1:0]   instr = '0;
  logic            pc_valid = 1'b0;
  logic            en = 1'b0;
  logic [3:0]      ctrl_addr = '0;
  logic [XLEN-1:0] ctrl_wdata = '0;
  logic            ctrl_write_enable = 1'b0;
  logic [DW-1:0]   dropped_count;
  logic [1:0]      gate_state;

  int checks = 0;
  int failures = 0;

  logic [63:0] pq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always #5 clk = ~clk;

  cms_trace_gate_if #(
    .XLEN(XLEN), .INSTR_WIDTH(IW), .TS_WIDTH(TSW)
  ) oif ();

  cms_trace_gate #(
    .XLEN(XLEN), .INSTR_WIDTH(IW),
    .NUM_RANGES(4), .NUM_TRIGGERS(2),
    .TS_WIDTH(TSW), .DECIM_WIDTH(16),
    .DROP_WIDTH(DW),
    .CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED(1)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc                (pc),
    .instr             (instr),
    .pc_valid          (pc_valid),
    .en                (en),
    .ctrl_addr         (ctrl_addr),
    .ctrl_wdata        (ctrl_wdata),
    .ctrl_write_enable (ctrl_write_enable),
    .out               (oif),
    .dropped_count     (dropped_count),
    .gate_state        (gate_state)
  );

  // Handshake happens at the next posedge; inputs settle after negedge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && oif.valid && oif.ready) begin
      pq.push_back(oif.pc);
      iq.push_back(oif.instr);
      dq.push_back(oif.delta);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int i);
    return (i < pq.size()) ? pq[i] : 64'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] dl(input int i);
    return (i < dq.size()) ? dq[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic clr_q();
    pq.delete();
    iq.delete();
    dq.delete();
  endtask

  task automatic send(input logic [63:0] p);
    @(negedge clk);
    pc = p;
    instr = p[31:0] ^ 32'hDEAD_BEEF;
    pc_valid = 1'b1;
  endtask

  task automatic quiet(input int n);
    @(negedge clk);
    pc_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    @(negedge clk);
    pc_valid = 1'b0;
    ctrl_addr = a;
    ctrl_wdata = d;
    ctrl_write_enable = 1'b1;
    @(negedge clk);
    ctrl_write_enable = 1'b0;
  endtask

  logic [63:0] e2 [3] = '{64'h2000, 64'h20FF, 64'h4000};
  logic [63:0] e3 [4] = '{64'h100, 64'h104, 64'h200, 64'h100};
  logic [63:0] s3 [6] = '{64'h0FC, 64'h100, 64'h104,
                          64'h200, 64'h204, 64'h100};

  initial begin
    oif.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(gate_state), 64'd0);
    chk("rst_valid", 64'(oif.valid), 64'd0);
    chk("rst_drop", 64'(dropped_count), 64'd0);
    rst_n = 1'b1;
    en = 1'b1;

    // free-run: no windows, no triggers
    wr(ADDR_CTRL, 64'h1);
    @(negedge clk);
    chk("t1_state", 64'(gate_state), 64'd2);
    clr_q();
    send(64'h1000);
    @(posedge clk);
    #1;
    chk("t1_lat_valid", 64'(oif.valid), 64'd1);
    chk("t1_lat_pc", oif.pc, 64'h1000);
    for (int i = 1; i < 5; i++) send(64'h1000 + 64'(4 * i));
    quiet(3);
    chk("t1_count", 64'(pq.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("t1_pc", pk(i), 64'h1000 + 64'(4 * i));
    for (int i = 1; i < 5; i++) chk("t1_delta", 64'(dl(i)), 64'd1);
    chk("t1_instr", 64'((iq.size() > 0) ? iq[0] : 32'h0),
        64'(32'hDEAD_BEEF ^ 32'h1000));

    // address windows, inclusive bounds
    wr(ADDR_INDEX, 64'd0);
    wr(ADDR_RANGE_LO, 64'h2000);
    wr(ADDR_RANGE_HI, 64'h20FF);
    wr(ADDR_RANGE_EN, 64'd1);
    wr(ADDR_INDEX, 64'd1);
    wr(ADDR_RANGE_LO, 64'h4000);
    wr(ADDR_RANGE_HI, 64'h4000);
    wr(ADDR_RANGE_EN, 64'd1);
    clr_q();
    send(64'h1FFC);
    send(64'h2000);
    send(64'h20FF);
    send(64'h2100);
    send(64'h4000);
    quiet(3);
    chk("t2_count", 64'(pq.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("t2_pc", pk(i), e2[i]);
    chk("t2_delta1", 64'(dl(1)), 64'd1);
    chk("t2_delta2", 64'(dl(2)), 64'd2);
    wr(ADDR_RANGE_EN, 64'd0);
    wr(ADDR_INDEX, 64'd0);
    wr(ADDR_RANGE_EN, 64'd0);

    // start/end triggers on slot 1, one-shot
    wr(ADDR_INDEX, 64'd1);
    wr(ADDR_TRIG_START, 64'h100);
    wr(ADDR_TRIG_END, 64'h200);
    wr(ADDR_TRIG_EN, 64'd3);
    wr(ADDR_CTRL, 64'h0);
    chk("t3_idle", 64'(gate_state), 64'd0);
    wr(ADDR_CTRL, 64'h1);
    @(negedge clk);
    chk("t3_armed", 64'(gate_state), 64'd1);
    clr_q();
    for (int i = 0; i < 6; i++) send(s3[i]);
    quiet(3);
    chk("t3_count", 64'(pq.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("t3_pc", pk(i), e3[i]);
    chk("t3_stopped", 64'(gate_state), 64'd3);

    // same sequence, continuous mode
    wr(ADDR_CTRL, 64'h3);
    clr_q();
    for (int i = 0; i < 6; i++) send(s3[i]);
    quiet(3);
    chk("t3c_count", 64'(pq.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("t3c_pc", pk(i), e3[i]);
    chk("t3c_state", 64'(gate_state), 64'd2);

    // decimation by 3
    wr(ADDR_CTRL, 64'h0);
    wr(ADDR_TRIG_EN, 64'd0);
    wr(ADDR_DECIM, 64'd2);
    wr(ADDR_CTRL, 64'h1);
    quiet(1);
    clr_q();
    for (int i = 0; i < 9; i++) send(64'h3000 + 64'(4 * i));
    quiet(3);
    chk("t4_count", 64'(pq.size()), 64'd3);
    chk("t4_pc0", pk(0), 64'h3008);
    chk("t4_pc1", pk(1), 64'h3014);
    chk("t4_pc2", pk(2), 64'h3020);
    chk("t4_delta", 64'(dl(1)), 64'd3);

    // backpressure and drop counter
    wr(ADDR_DECIM, 64'd0);
    clr_q();
    oif.ready = 1'b0;
    for (int i = 0; i < 4; i++) send(64'h5000 + 64'(4 * i));
    quiet(2);
    chk("t5_hold_valid", 64'(oif.valid), 64'd1);
    chk("t5_hold_pc", oif.pc, 64'h5000);
    chk("t5_drop3", 64'(dropped_count), 64'd3);
    @(negedge clk);
    pc = 64'h5010;
    pc_valid = 1'b1;
    ctrl_addr = ADDR_CTRL;
    ctrl_wdata = 64'h5;
    ctrl_write_enable = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    ctrl_write_enable = 1'b0;
    chk("t5_clr_wins", 64'(dropped_count), 64'd0);
    for (int i = 0; i < 8; i++) send(64'h6000 + 64'(4 * i));
    quiet(1);
    chk("t5_saturate", 64'(dropped_count), 64'd7);
    chk("t5_still_pc", oif.pc, 64'h5000);
    oif.ready = 1'b1;
    @(negedge clk);
    chk("t5_drain_n", 64'(pq.size()), 64'd1);
    chk("t5_drain_pc", pk(0), 64'h5000);
    chk("t5_drained", 64'(oif.valid), 64'd0);

    // disarm wins over a simultaneous start match
    wr(ADDR_TRIG_EN, 64'd1);
    clr_q();
    @(negedge clk);
    pc = 64'h100;
    pc_valid = 1'b1;
    ctrl_addr = ADDR_CTRL;
    ctrl_wdata = 64'h0;
    ctrl_write_enable = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    ctrl_write_enable = 1'b0;
    chk("t6_idle", 64'(gate_state), 64'd0);
    quiet(2);
    chk("t6_nocap", 64'(pq.size()), 64'd0);
    chk("t6_novalid", 64'(oif.valid), 64'd0);

    // reset mid-trace with a held packet
    wr(ADDR_CTRL, 64'h1);
    oif.ready = 1'b0;
    send(64'h100);
    @(negedge clk);
    pc_valid = 1'b0;
    chk("t7_pre_valid", 64'(oif.valid), 64'd1);
    chk("t7_pre_state", 64'(gate_state), 64'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t7_valid", 64'(oif.valid), 64'd0);
    chk("t7_pc", oif.pc, 64'd0);
    chk("t7_delta", 64'(oif.delta), 64'd0);
    chk("t7_state", 64'(gate_state), 64'd0);
    chk("t7_drop", 64'(dropped_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    oif.ready = 1'b1;
    clr_q();
    // reset slot 0 is [0, all-ones]; enabling it must pass everything
    wr(ADDR_RANGE_EN, 64'd1);
    wr(ADDR_CTRL, 64'h1);
    quiet(1);
    chk("t7_rearm", 64'(gate_state), 64'd2);
    send(64'h7777);
    send(64'hFFFF_FFFF_FFFF_FFF0);
    quiet(2);
    chk("t7_count", 64'(pq.size()), 64'd2);
    chk("t7_pc0", pk(0), 64'h7777);
    chk("t7_pc1", pk(1), 64'hFFFF_FFFF_FFFF_FFF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
